// File: rtl/sub_pkg.sv
//-----------------------------------------------------------------------------
// Module   : sub_pkg
// Brief    : Shared types and constants for the nibble-serial subtractor.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

   // Width of one arithmetic slice processed per clock.
   localparam int SLICE_W = 4;

   // Controller states; explicit 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sub_nibble.sv
//-----------------------------------------------------------------------------
// Module   : sub_nibble
// Brief    : 4-bit combinational subtract slice with borrow in/out and a
//            signed-overflow indication for use on the most significant slice.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module sub_nibble
   import sub_pkg::*;
(
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               bi,
   output logic [SLICE_W-1:0] d,
   output logic               bo,
   output logic               v
);

   // 5-bit two's-complement result: the top bit is set exactly when x-y-bi < 0,
   // which is the borrow out of this slice.
   logic [SLICE_W:0] w_res;

   assign w_res = {1'b0, x} - {1'b0, y} - {{SLICE_W{1'b0}}, bi};
   assign d     = w_res[SLICE_W-1:0];
   assign bo    = w_res[SLICE_W];

   // Signed overflow: operands of opposite sign and the result sign differs
   // from the minuend. The borrow-in cannot cause overflow on its own when
   // the operand signs match, so this form covers x - y - bi.
   assign v = (x[SLICE_W-1] != y[SLICE_W-1]) && (d[SLICE_W-1] != x[SLICE_W-1]);

endmodule

`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
//-----------------------------------------------------------------------------
// Module   : nibble_serial_subtractor
// Brief    : Multi-cycle subtractor, diff = a - b - bin over WIDTH bits,
//            one 4-bit slice per clock (LSB first) with rippled borrow.
//            Valid/ready handshakes on both operand and result sides.
//            Optional macro SUB_OVERFLOW_FLAG_EN adds a signed-overflow
//            output port ovf.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module nibble_serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_OVERFLOW_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / SLICE_W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] c_last = CW'(N - 1);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_borrow;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_diff;
   logic               r_bout;
   logic [SLICE_W-1:0] w_x;
   logic [SLICE_W-1:0] w_y;
   logic [SLICE_W-1:0] w_d;
   logic               w_bo;
   logic               w_v;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: accept in IDLE, walk the slices in RUN, hold in DONE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)          w_next = RUN;
         RUN:     if (r_cnt == c_last)   w_next = DONE;
         DONE:    if (out_ready)         w_next = IDLE;
         default:                        w_next = IDLE;
      endcase
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);

   // Select the operand slice addressed by the counter.
   always_comb begin
      w_x = '0;
      w_y = '0;
      for (int k = 0; k < N; k++) begin
         if (r_cnt == CW'(k)) begin
            w_x = r_a[k*SLICE_W +: SLICE_W];
            w_y = r_b[k*SLICE_W +: SLICE_W];
         end
      end
   end

   sub_nibble u_slice (
      .x  (w_x),
      .y  (w_y),
      .bi (r_borrow),
      .d  (w_d),
      .bo (w_bo),
      .v  (w_v)
   );

   // Datapath: latch operands on accept, write one result slice per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= bin;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               for (int k = 0; k < N; k++) begin
                  if (r_cnt == CW'(k)) r_diff[k*SLICE_W +: SLICE_W] <= w_d;
               end
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == c_last) r_bout <= w_bo;
            end
            default: ;
         endcase
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;

`ifdef SUB_OVERFLOW_FLAG_EN
   logic r_ovf;

   // Overflow is captured from the most significant slice only.
   always_ff @(posedge clk) begin
      if (rst)                                      r_ovf <= 1'b0;
      else if (r_state == RUN && r_cnt == c_last)   r_ovf <= w_v;
   end

   assign ovf = r_ovf;
`else
   // Slice overflow bit has no consumer in this build.
   logic w_unused_v;
   assign w_unused_v = w_v;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
//-----------------------------------------------------------------------------
// Module   : tb_nibble_serial_subtractor
// Brief    : Self-checking bench for nibble_serial_subtractor (WIDTH=16).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_subtractor;

   localparam int WIDTH = 16;
   localparam int NSL   = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   int n_cmp;
   int n_err;

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SUB_OVERFLOW_FLAG_EN
      ,
      .ovf       (ovf)
`endif
   );

`ifndef SUB_OVERFLOW_FLAG_EN
   assign ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic        vbin;
      int          stall;
      logic [15:0] ediff;
      logic        ebout;
      logic        eovf;
   } vec_t;

   // Reference: unsigned (WIDTH+1)-bit arithmetic gives {bout,diff}.
   function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                           input logic bi);
      return {1'b0, x} - {1'b0, y} - {16'b0, bi};
   endfunction

   // Reference: true signed result compared against the 16-bit signed range.
   function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y,
                                    input logic bi);
      int r;
      r = int'($signed(x)) - int'($signed(y)) - int'(bi);
      return (r > 32767) || (r < -32768);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for in_ready, present operands for one accept edge.
   task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      bin      = tbin;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
   endtask

   // Check latency, result, stability under backpressure and the handshake.
   task automatic finish_op(input string nm, input logic [15:0] ed, input logic eb,
                            input logic eo, input int stall);
      int lat;
      logic [15:0] hd;
      logic        hb;
      logic        ho;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({nm, "_latency"}, 32'(lat), 32'(NSL));
      check({nm, "_diff"}, 32'(diff), 32'(ed));
      check({nm, "_bout"}, 32'(bout), 32'(eb));
`ifdef SUB_OVERFLOW_FLAG_EN
      check({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
      ho = eo;
`endif
      hd = diff;
      hb = bout;
      ho = ovf;
      for (int i = 0; i < stall; i++) begin
         tick();
         check({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
         check({nm, "_stall_inrdy"}, 32'(in_ready), 32'd0);
         check({nm, "_stall_diff"}, 32'(diff), 32'(hd));
         check({nm, "_stall_bout"}, 32'(bout), 32'(hb));
`ifdef SUB_OVERFLOW_FLAG_EN
         check({nm, "_stall_ovf"}, 32'(ovf), 32'(ho));
`endif
      end
      out_ready = 1'b1;
      check({nm, "_pre_hs_inrdy"}, 32'(in_ready), 32'd0);
      tick();
      out_ready = 1'b0;
      check({nm, "_post_valid"}, 32'(out_valid), 32'd0);
      check({nm, "_post_inrdy"}, 32'(in_ready), 32'd1);
      check({nm, "_post_hold"}, 32'({bout, diff}), 32'({hb, hd}));
   endtask

   vec_t vecs[6];

   initial begin
      logic [16:0] r;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbi;
      n_cmp = 0;
      n_err = 0;

      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 0, 16'h1000, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 0, 16'h0000, 1'b0, 1'b1};
      vecs[3] = '{16'h5A5A, 16'h5A5A, 1'b0, 2, 16'h0000, 1'b0, 1'b0};
      vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 5, 16'h8000, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_bout", 32'(bout), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         start_op(vecs[i].va, vecs[i].vb, vecs[i].vbin);
         finish_op($sformatf("vec%0d", i), vecs[i].ediff, vecs[i].ebout, vecs[i].eovf,
                   vecs[i].stall);
      end

      // in_valid held with new operands during RUN must be ignored.
      start_op(16'h00FF, 16'h0001, 1'b0);
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; bin = 1'b1;
      for (int i = 0; i < NSL - 1; i++) begin
         check("hold_run_inrdy", 32'(in_ready), 32'd0);
         tick();
      end
      tick();
      check("hold_done_valid", 32'(out_valid), 32'd1);
      check("hold_first_diff", 32'({bout, diff}), 32'({1'b0, 16'h00FE}));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_idle_inrdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      r = ref_sub(16'hAAAA, 16'h5555, 1'b1);
      finish_op("hold_second", r[15:0], r[16], ref_ovf(16'hAAAA, 16'h5555, 1'b1), 0);

      // Reset mid-RUN (counter = 2) aborts and clears outputs.
      start_op(16'h1357, 16'h0246, 1'b1);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_diff", 32'(diff), 32'd0);
      check("midrst_bout", 32'(bout), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      start_op(16'hFFFF, 16'hFFFF, 1'b0);
      finish_op("after_rst", 16'h0000, 1'b0, 1'b0, 0);

      // Randomized operations against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         int st;
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rbi = 1'($urandom);
         st  = int'($urandom_range(0, 3));
         r   = ref_sub(ra, rb, rbi);
         start_op(ra, rb, rbi);
         finish_op($sformatf("rand%0d", i), r[15:0], r[16], ref_ovf(ra, rb, rbi), st);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits, one 4-bit slice per clock, LSB slice first, rippling the borrow between cycles.
It is the inverse-operation companion of the team's 4-bit adder and sits in the same datapath wherever a subtract is needed.
Operands enter on a valid/ready handshake and results leave on a valid/ready handshake, so it can stall against upstream and downstream logic.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4; number of slices N = WIDTH/4.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset; synchronous and active-high.
in_valid  input  1  operands a, b, bin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
out_valid  output  1  diff and bout are valid.
out_ready  input  1  consumer accepts the result.
diff  output  WIDTH  difference, a - b - bin mod 2^WIDTH.
bout  output  1  borrow out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (sync, active-high, any state): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, slice counter=0. Reset mid-RUN or mid-DONE aborts the operation and the result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b and bin; set borrow register = bin; counter=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and no operand is latched.
  - Each cycle, slice k=counter: {borrow', d} = a[4k+3:4k] - b[4k+3:4k] - borrow, computed as a 5-bit two's-complement result.
  - d is written to diff[4k+3:4k]; borrow is updated; counter increments.
  - After slice N-1 is written: bout = final borrow; go to DONE.
- DONE:
  - out_valid=1; diff and bout are stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On out_ready: go to IDLE.
  - in_ready rises the following cycle. There is no same-cycle turnaround.
- Latency: operand handshake at edge T; out_valid=1 from edge T+N. Throughput is one operation per N+2 cycles with no stalls.
- diff and bout hold their last result after DONE until the next accept. Intermediate slices of diff are visible during RUN but are not valid until out_valid=1.
- Arithmetic: purely unsigned modular. Result bit-exact to {bout,diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1).
- Boundaries:
  - a=b, bin=0 -> diff=0, bout=0.
  - a=0, b=0, bin=1 -> diff=all ones, bout=1.
  - WIDTH=4 -> N=1, out_valid at T+1.
  - Counter is sized $clog2(N) bits, with a minimum width of 1.

Optional Feature:
Macro SUB_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit), valid with out_valid, reset 0, held like diff.
  - ovf=1 iff the signed (two's-complement) result a - b - bin is outside the WIDTH-bit signed range.
  - ovf is computed in the last slice as (a_msb != b_msb) && (diff_msb != a_msb), with bin folded in via the ripple.
- Undefined: port absent; no overflow logic synthesized; all other behaviour identical.

Decomposition:
- Package sub_pkg: state enum (IDLE, RUN, DONE) and constant SLICE_W=4.
- One natural combinational sub-module sub_nibble: inputs x[3:0], y[3:0], bi; outputs d[3:0], bo, plus signed-overflow bit v.
- Top instantiates sub_nibble once and muxes the slice selected by counter.

Test Plan:
All scenarios use WIDTH=16.
1. a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0; out_valid exactly 4 cycles after the accept edge.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. With SUB_OVERFLOW_FLAG_EN, ovf=0.
3. a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0. With SUB_OVERFLOW_FLAG_EN, ovf=1.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid, diff and bout stable throughout.
   - in_ready=0 until the cycle after out_ready is seen.
5. in_valid held high with new operands during RUN -> ignored; result matches the first operands; second operands accepted only once back in IDLE.
6. Assert rst for 1 cycle during RUN (counter=2) -> next cycle IDLE, in_ready=1, out_valid=0, diff=0, bout=0; a fresh op 0xFFFF-0xFFFF -> diff=0x0000, bout=0.
